sync_flop: RTL and testbench

//   Multi-stage flip-flop synchronizer that brings an asynchronous or foreign-domain

---
 rtl/sync_flop.sv | 58 +++++
 tb/tb_sync_flop.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_flop.sv
// Multi-stage flip-flop synchronizer for level signals entering the clk domain.
// Each bit is synchronized independently; rise/fall pulses are derived from the
// synchronized level and its one-cycle-delayed copy.
module sync_flop #(
    parameter int FLOPS   = 2,  // synchronizer depth, legal range 2..8
    parameter int WIDTH   = 1,  // independent bits, no bus coherency
    parameter int RST_VAL = 0   // bit 0 replicated into every stage on reset
) (
    input  logic             clk,
    input  logic             rstn,  // active-high synchronous reset
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RST_VAL[0]}};

    // A single stage gives no metastability protection at all.
    if (FLOPS < 2) begin : g_flops_too_few
        $error("sync_flop: FLOPS must be at least 2");
    end
    if (FLOPS > 8) begin : g_flops_too_many
        $error("sync_flop: FLOPS must not exceed 8");
    end

    // Stage 0 may go metastable; the attributes keep these flops as a plain,
    // adjacent chain so synthesis does not retime, merge or pack them into SRLs.
    (* ASYNC_REG = "TRUE", dont_touch = "true", shreg_extract = "no" *)
    logic [WIDTH-1:0] r_stage [FLOPS];

    // Registered copy of sync used for edge detection.
    logic [WIDTH-1:0] r_prev;

    // Shift the chain one stage per clock; reset overrides in-flight values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < FLOPS; i++) begin
                r_stage[i] <= RST_WORD;
            end
            r_prev <= RST_WORD;
        end else begin
            r_stage[0] <= data;
            for (int i = 1; i < FLOPS; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_prev <= r_stage[FLOPS-1];
        end
    end

    // Output level straight from the last flop; pulses from flop-to-flop compare.
    always_comb begin
        sync = r_stage[FLOPS-1];
        rise = r_stage[FLOPS-1] & ~r_prev;
        fall = ~r_stage[FLOPS-1] & r_prev;
    end

endmodule

// File: tb/tb_sync_flop.sv
// Self-checking bench for sync_flop: three configurations share one clock,
// reset and data bus, and are compared against a history-based reference model.
module tb_sync_flop;

    localparam int LOG_DEPTH = 16384;

    logic       clk;
    logic       rst;
    logic [3:0] data;

    logic       sync_a, rise_a, fall_a;  // FLOPS=2, WIDTH=1, RST_VAL=0
    logic       sync_b, rise_b, fall_b;  // FLOPS=4, WIDTH=1, RST_VAL=0
    logic [3:0] sync_c, rise_c, fall_c;  // FLOPS=2, WIDTH=4, RST_VAL=1

    int checks;
    int errors;

    // Per-edge record of what each posedge saw on rst and data.
    int         edge_cnt;
    logic [3:0] data_log [LOG_DEPTH];
    logic       rst_log  [LOG_DEPTH];

    sync_flop #(.FLOPS(2), .WIDTH(1), .RST_VAL(0)) u_dut_a (
        .clk  (clk),
        .rstn (rst),
        .data (data[0]),
        .sync (sync_a),
        .rise (rise_a),
        .fall (fall_a)
    );

    sync_flop #(.FLOPS(4), .WIDTH(1), .RST_VAL(0)) u_dut_b (
        .clk  (clk),
        .rstn (rst),
        .data (data[0]),
        .sync (sync_b),
        .rise (rise_b),
        .fall (fall_b)
    );

    sync_flop #(.FLOPS(2), .WIDTH(4), .RST_VAL(1)) u_dut_c (
        .clk  (clk),
        .rstn (rst),
        .data (data),
        .sync (sync_c),
        .rise (rise_c),
        .fall (fall_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (edge_cnt < LOG_DEPTH) begin
            data_log[edge_cnt] <= data;
            rst_log[edge_cnt]  <= rst;
        end
        edge_cnt <= edge_cnt + 1;
    end

    // Level seen on sync after edge n: the data captured f-1 edges earlier,
    // unless any edge in that window was a reset edge.
    function automatic logic [3:0] m_sync(int n, int f, logic [3:0] rv);
        for (int j = n - f + 1; j <= n; j++) begin
            if (j < 0 || j >= LOG_DEPTH) return rv;
            if (rst_log[j]) return rv;
        end
        return data_log[n-f+1];
    endfunction

    // Previous-cycle sync after edge n (reset forces it to the reset value).
    function automatic logic [3:0] m_prev(int n, int f, logic [3:0] rv);
        if (n < 0 || n >= LOG_DEPTH) return rv;
        if (rst_log[n]) return rv;
        return m_sync(n - 1, f, rv);
    endfunction

    // Apply current inputs on the next posedge, then settle at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data = 4'($urandom);
            step();
            checks++;
            if ({sync_a, rise_a, fall_a, sync_b, rise_b, fall_b, sync_c, rise_c, fall_c}
                !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hf, 4'h0, 4'h0}) begin
                errors++;
                $display("FAIL reset[%0d]: got a=%b%b%b b=%b%b%b c=%h/%h/%h, expected a=000 b=000 c=f/0/0",
                         k, sync_a, rise_a, fall_a, sync_b, rise_b, fall_b,
                         sync_c, rise_c, fall_c);
            end
        end
    endtask

    task automatic test_release_rise();
        rst  = 1'b1;
        data = 4'hf;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if ({sync_a, rise_a, fall_a} !== {k >= 2, k == 2, 1'b0}) begin
                errors++;
                $display("FAIL release_rise_a[%0d]: got %b%b%b expected %b%b0",
                         k, sync_a, rise_a, fall_a, k >= 2, k == 2);
            end
            checks++;
            if ({sync_b, rise_b, fall_b} !== {k >= 4, k == 4, 1'b0}) begin
                errors++;
                $display("FAIL release_rise_b[%0d]: got %b%b%b expected %b%b0",
                         k, sync_b, rise_b, fall_b, k >= 4, k == 4);
            end
        end
    endtask

    task automatic test_fall_latency();
        data = 4'h0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if ({sync_a, rise_a, fall_a} !== {k < 2, 1'b0, k == 2}) begin
                errors++;
                $display("FAIL fall_a[%0d]: got %b%b%b expected %b0%b",
                         k, sync_a, rise_a, fall_a, k < 2, k == 2);
            end
            checks++;
            if ({sync_b, rise_b, fall_b} !== {k < 4, 1'b0, k == 4}) begin
                errors++;
                $display("FAIL fall_b[%0d]: got %b%b%b expected %b0%b",
                         k, sync_b, rise_b, fall_b, k < 4, k == 4);
            end
        end
    endtask

    task automatic test_reset_midflight();
        data = 4'h1;
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({sync_a, rise_a, sync_b, rise_b} !== 4'b0000) begin
            errors++;
            $display("FAIL midflight_reset: got a=%b%b b=%b%b expected a=00 b=00",
                     sync_a, rise_a, sync_b, rise_b);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if ({sync_a, rise_a, fall_a} !== {k >= 2, k == 2, 1'b0}) begin
                errors++;
                $display("FAIL midflight_a[%0d]: got %b%b%b expected %b%b0",
                         k, sync_a, rise_a, fall_a, k >= 2, k == 2);
            end
            checks++;
            if ({sync_b, rise_b, fall_b} !== {k >= 4, k == 4, 1'b0}) begin
                errors++;
                $display("FAIL midflight_b[%0d]: got %b%b%b expected %b%b0",
                         k, sync_b, rise_b, fall_b, k >= 4, k == 4);
            end
        end
    endtask

    task automatic test_rstval_wide();
        logic [3:0] exp_s [4];
        logic [3:0] exp_f [4];
        exp_s = '{4'hf, 4'hf, 4'h5, 4'h5};
        exp_f = '{4'h0, 4'h0, 4'ha, 4'h0};
        rst  = 1'b1;
        data = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            rst = 1'b0;
            checks++;
            if ({sync_c, rise_c, fall_c} !== {exp_s[k], 4'h0, exp_f[k]}) begin
                errors++;
                $display("FAIL rstval_c[%0d]: got sync=%h rise=%h fall=%h expected sync=%h rise=0 fall=%h",
                         k, sync_c, rise_c, fall_c, exp_s[k], exp_f[k]);
            end
        end
    endtask

    task automatic test_random();
        int         hold;
        int         n;
        logic [3:0] s, p;
        hold = 0;
        for (int c = 0; c < 10000; c++) begin
            if (hold == 0) begin
                data = 4'($urandom);
                hold = int'($urandom_range(1, 4));
            end
            hold--;
            rst = ($urandom_range(0, 199) == 0);
            step();
            n = edge_cnt - 1;

            s = m_sync(n, 2, 4'h0);
            p = m_prev(n, 2, 4'h0);
            checks++;
            if ({sync_a, rise_a, fall_a} !== {s[0], s[0] & ~p[0], ~s[0] & p[0]}) begin
                errors++;
                $display("FAIL random_a[%0d]: got %b%b%b expected %b%b%b", c,
                         sync_a, rise_a, fall_a, s[0], s[0] & ~p[0], ~s[0] & p[0]);
            end

            s = m_sync(n, 4, 4'h0);
            p = m_prev(n, 4, 4'h0);
            checks++;
            if ({sync_b, rise_b, fall_b} !== {s[0], s[0] & ~p[0], ~s[0] & p[0]}) begin
                errors++;
                $display("FAIL random_b[%0d]: got %b%b%b expected %b%b%b", c,
                         sync_b, rise_b, fall_b, s[0], s[0] & ~p[0], ~s[0] & p[0]);
            end

            s = m_sync(n, 2, 4'hf);
            p = m_prev(n, 2, 4'hf);
            checks++;
            if ({sync_c, rise_c, fall_c} !== {s, s & ~p, ~s & p}) begin
                errors++;
                $display("FAIL random_c[%0d]: got %h/%h/%h expected %h/%h/%h", c,
                         sync_c, rise_c, fall_c, s, s & ~p, ~s & p);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        rst      = 1'b1;
        data     = 4'h0;
        @(negedge clk);
        test_reset();
        test_release_rise();
        test_fall_latency();
        test_reset_midflight();
        test_rstval_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
